// File: rtl/stack_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : stack_pkg
// Description : Shared encodings for the stack-pointer controller: request
//               opcodes, FSM state constants and a word-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

  // Request opcodes carried on op[1:0]
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Controller FSM state encoding
  localparam int         STATE_W   = 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  // Number of stack words a PUSH/POP moves, from the op_words flag
  function automatic logic [1:0] op_count(input logic words);
    return words ? 2'd2 : 2'd1;
  endfunction

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_bounds_check.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : stack_bounds_check
// Description : Combinational legality check for one stack request. Computes
//               whether the request fits the stack window, which error flag a
//               rejection raises, and the stack pointer after the request.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_bounds_check
  import stack_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int STACK_TOP = 2047,
  parameter int DEPTH     = 2048
) (
  input  logic [ADDR_W-1:0] sp,
  input  logic [1:0]        op,
  input  logic              op_words,
  input  logic [ADDR_W-1:0] load_value,
  output logic              legal,
  output logic              set_ovf,
  output logic              set_unf,
  output logic [ADDR_W-1:0] next_sp
);

  // Window bounds at address width. The limit may wrap below zero (default
  // configuration gives limit = all-ones); the modular arithmetic below keeps
  // used/free counts correct in that case as long as sp stays in the window.
  localparam logic [ADDR_W-1:0] c_top   = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W-1:0] c_limit = ADDR_W'(STACK_TOP - DEPTH);
  localparam logic [ADDR_W-1:0] c_depth = ADDR_W'(DEPTH);

  logic [ADDR_W-1:0] w_used;
  logic [ADDR_W-1:0] w_free;
  logic [ADDR_W-1:0] w_n;
  logic [ADDR_W-1:0] w_load_off;

  assign w_used     = c_top - sp;
  assign w_free     = sp - c_limit;
  assign w_n        = ADDR_W'(op_count(op_words));
  // Distance of the requested SP above the limit; in range iff <= DEPTH.
  assign w_load_off = load_value - c_limit;

  // Decide legality and the resulting stack pointer for the presented request
  always_comb begin
    legal   = 1'b1;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    next_sp = sp;
    case (op)
      OP_PUSH: begin
        if (w_free >= w_n) begin
          next_sp = sp - w_n;
        end else begin
          legal   = 1'b0;
          set_ovf = 1'b1;
        end
      end
      OP_POP: begin
        if (w_used >= w_n) begin
          next_sp = sp + w_n;
        end else begin
          legal   = 1'b0;
          set_unf = 1'b1;
        end
      end
      OP_LOAD: begin
        if (w_load_off <= c_depth) begin
          next_sp = load_value;
        end else begin
          legal = 1'b0;
          // Above the top means an underflowed stack, otherwise below limit
          if (load_value > c_top) begin
            set_unf = 1'b1;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end
      default: begin
        // NOP: always legal, pointer unchanged
      end
    endcase
  end

endmodule : stack_bounds_check
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : stack_ctrl
// Description : Stack-pointer controller for the memory stage. Accepts
//               PUSH/POP/LOAD requests of one or two words, sequences the
//               memory beats, tracks SP against a configurable window and
//               reports rejected requests via sticky flags and an exc pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int STACK_TOP = 2047,
  parameter int DEPTH     = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic              op_words,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              stall,
  input  logic              clr_flags,
  output logic              ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              word_idx,
  output logic [ADDR_W-1:0] sp,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              exc
);

  localparam logic [ADDR_W-1:0] c_top   = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W-1:0] c_limit = ADDR_W'(STACK_TOP - DEPTH);
  localparam logic [ADDR_W-1:0] c_one   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_two   = ADDR_W'(2);

  logic [STATE_W-1:0] r_state;
  logic [ADDR_W-1:0]  r_sp;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_word_idx;
  logic [ADDR_W-1:0]  r_beat1_addr;
  logic               r_ovf;
  logic               r_unf;
  logic               r_exc;

  logic               w_accept;
  logic               w_legal;
  logic               w_set_ovf;
  logic               w_set_unf;
  logic [ADDR_W-1:0]  w_next_sp;
  logic               w_is_push;
  logic               w_is_pop;
  logic               w_rej_ovf;
  logic               w_rej_unf;

  stack_bounds_check #(
    .ADDR_W    (ADDR_W),
    .STACK_TOP (STACK_TOP),
    .DEPTH     (DEPTH)
  ) u_bounds (
    .sp         (r_sp),
    .op         (op),
    .op_words   (op_words),
    .load_value (load_value),
    .legal      (w_legal),
    .set_ovf    (w_set_ovf),
    .set_unf    (w_set_unf),
    .next_sp    (w_next_sp)
  );

  // A second beat in flight blocks new requests; stall blocks acceptance.
  assign ready     = (r_state == ST_IDLE);
  assign w_accept  = op_valid & ready & ~stall;
  assign w_is_push = (op == OP_PUSH);
  assign w_is_pop  = (op == OP_POP);
  // Flags are raised only by a rejected request; bounds check flags only
  // assert when the request is illegal.
  assign w_rej_ovf = w_accept & w_set_ovf;
  assign w_rej_unf = w_accept & w_set_unf;

  // FSM, stack pointer, beat sequencing and error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_sp         <= c_top;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_word_idx   <= 1'b0;
      r_beat1_addr <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_exc        <= 1'b0;
    end else if (!stall) begin
      r_mem_en <= 1'b0;
      r_exc    <= 1'b0;
      // A new error in the same cycle as clr_flags keeps the flag set
      r_ovf    <= w_rej_ovf | (r_ovf & ~clr_flags);
      r_unf    <= w_rej_unf | (r_unf & ~clr_flags);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_legal) begin
              r_exc <= 1'b1;
            end else begin
              r_sp <= w_next_sp;
              if (w_is_push || w_is_pop) begin
                r_mem_en <= 1'b1;
                r_mem_we <= w_is_push;
                // Push writes word 0 at sp then word 1 below it; pop reads
                // back in mirror order starting from the top-of-stack word.
                if (w_is_push) begin
                  r_mem_addr   <= r_sp;
                  r_word_idx   <= 1'b0;
                  r_beat1_addr <= r_sp - c_one;
                end else begin
                  r_mem_addr   <= r_sp + c_one;
                  r_word_idx   <= op_words;
                  r_beat1_addr <= r_sp + c_two;
                end
                if (op_words) begin
                  r_state <= ST_SECOND;
                end
              end
            end
          end
        end
        ST_SECOND: begin
          // Second beat: push carries word 1, pop carries word 0
          r_mem_en   <= 1'b1;
          r_mem_addr <= r_beat1_addr;
          r_word_idx <= r_mem_we;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign word_idx  = r_word_idx;
  assign sp        = r_sp;
  assign empty     = (r_sp == c_top);
  assign full      = (r_sp == c_limit);
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign exc       = r_exc;

endmodule : stack_ctrl
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_stack_ctrl
// Description : Self-checking bench for stack_ctrl. Two instances share the
//               stimulus: default window (a) and a four-slot window (b).
//               Expected memory beats are queued when a request is driven and
//               compared as the selected instance presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;
  import stack_pkg::*;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_words, stall, clr_flags, sel;
  logic [1:0]  op;
  logic [31:0] load_value;

  logic        a_ready, a_mem_en, a_mem_we, a_word_idx, a_empty, a_full, a_ovf, a_unf, a_exc;
  logic [31:0] a_mem_addr, a_sp;
  logic        b_ready, b_mem_en, b_mem_we, b_word_idx, b_empty, b_full, b_ovf, b_unf, b_exc;
  logic [31:0] b_mem_addr, b_sp;
  logic        m_ready, m_mem_en, m_mem_we, m_word_idx, m_empty, m_full, m_ovf, m_unf, m_exc;
  logic [31:0] m_mem_addr, m_sp;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        idx;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.ADDR_W(32), .STACK_TOP(2047), .DEPTH(2048)) u_dut_a (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_words(op_words),
    .load_value(load_value), .stall(stall), .clr_flags(clr_flags),
    .ready(a_ready), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .word_idx(a_word_idx), .sp(a_sp), .empty(a_empty), .full(a_full),
    .overflow(a_ovf), .underflow(a_unf), .exc(a_exc)
  );

  stack_ctrl #(.ADDR_W(32), .STACK_TOP(2047), .DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_words(op_words),
    .load_value(load_value), .stall(stall), .clr_flags(clr_flags),
    .ready(b_ready), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .word_idx(b_word_idx), .sp(b_sp), .empty(b_empty), .full(b_full),
    .overflow(b_ovf), .underflow(b_unf), .exc(b_exc)
  );

  // Observe the instance under test
  always_comb begin
    m_ready    = sel ? b_ready    : a_ready;
    m_mem_en   = sel ? b_mem_en   : a_mem_en;
    m_mem_we   = sel ? b_mem_we   : a_mem_we;
    m_mem_addr = sel ? b_mem_addr : a_mem_addr;
    m_word_idx = sel ? b_word_idx : a_word_idx;
    m_sp       = sel ? b_sp       : a_sp;
    m_empty    = sel ? b_empty    : a_empty;
    m_full     = sel ? b_full     : a_full;
    m_ovf      = sel ? b_ovf      : a_ovf;
    m_unf      = sel ? b_unf      : a_unf;
    m_exc      = sel ? b_exc      : a_exc;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // A beat is consumed on a cycle where it is presented and not stalled
  always @(negedge clk) begin
    if (m_mem_en === 1'b1 && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        check_eq("beat_unexpected", 64'(m_mem_en), 64'd0);
      end else begin
        check_eq("beat", {m_mem_addr, m_mem_we, m_word_idx}, 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic we, input logic idx);
    beat_t b;
    b.addr = a;
    b.we   = we;
    b.idx  = idx;
    exp_q.push_back(b);
  endtask

  task automatic do_op(input logic [1:0] o, input logic w, input logic [31:0] lv);
    op_valid   = 1'b1;
    op         = o;
    op_words   = w;
    load_value = lv;
    tick();
    op_valid   = 1'b0;
    op         = OP_NOP;
    op_words   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op = OP_NOP; op_words = 1'b0;
    load_value = '0; stall = 1'b0; clr_flags = 1'b0; sel = 1'b0;

    // ---------------- default window ----------------
    do_reset();
    check_eq("rst_sp", m_sp, 2047);
    check_eq("rst_empty", m_empty, 1);
    check_eq("rst_full", m_full, 0);
    check_eq("rst_ready", m_ready, 1);
    check_eq("rst_mem_en", m_mem_en, 0);
    check_eq("rst_mem_addr", m_mem_addr, 0);
    check_eq("rst_ovf", m_ovf, 0);
    check_eq("rst_unf", m_unf, 0);
    check_eq("rst_exc", m_exc, 0);

    // Three back-to-back single-word pushes
    for (int i = 0; i < 3; i++) begin
      exp_beat(32'(2047 - i), 1'b1, 1'b0);
      do_op(OP_PUSH, 1'b0, 0);
    end
    check_eq("push3_sp", m_sp, 2044);
    check_eq("push3_empty", m_empty, 0);

    // Two-word pop: one busy cycle, mirrored beat order
    exp_beat(2045, 1'b0, 1'b1);
    exp_beat(2046, 1'b0, 1'b0);
    do_op(OP_POP, 1'b1, 0);
    check_eq("pop2_busy", m_ready, 0);
    check_eq("pop2_sp", m_sp, 2046);
    tick();
    check_eq("pop2_ready_again", m_ready, 1);

    exp_beat(2047, 1'b0, 1'b0);
    do_op(OP_POP, 1'b0, 0);
    check_eq("pop1_sp", m_sp, 2047);
    check_eq("pop1_empty", m_empty, 1);

    // Pop from empty stack is rejected
    do_op(OP_POP, 1'b0, 0);
    check_eq("unf_exc", m_exc, 1);
    check_eq("unf_flag", m_unf, 1);
    check_eq("unf_sp", m_sp, 2047);
    check_eq("unf_no_beat", m_mem_en, 0);
    tick();
    check_eq("exc_one_cycle", m_exc, 0);
    check_eq("unf_sticky", m_unf, 1);

    // Set beats clear in the same cycle
    clr_flags = 1'b1;
    do_op(OP_POP, 1'b0, 0);
    clr_flags = 1'b0;
    check_eq("unf_set_wins", m_unf, 1);
    check_eq("unf_set_wins_exc", m_exc, 1);
    clear_flags();
    check_eq("unf_cleared", m_unf, 0);

    // LOAD in range, then out of range above the top
    do_op(OP_LOAD, 1'b0, 1000);
    check_eq("load_sp", m_sp, 1000);
    check_eq("load_no_beat", m_mem_en, 0);
    check_eq("load_no_exc", m_exc, 0);
    do_op(OP_LOAD, 1'b0, 5000);
    check_eq("load_hi_unf", m_unf, 1);
    check_eq("load_hi_ovf", m_ovf, 0);
    check_eq("load_hi_sp", m_sp, 1000);
    check_eq("load_hi_exc", m_exc, 1);
    clear_flags();

    // Two-word push with stall on the second beat
    do_op(OP_LOAD, 1'b0, 2047);
    exp_beat(2047, 1'b1, 1'b0);
    exp_beat(2046, 1'b1, 1'b1);
    do_op(OP_PUSH, 1'b1, 0);
    check_eq("push2_sp", m_sp, 2045);
    tick();
    stall    = 1'b1;
    op_valid = 1'b1;
    op       = OP_PUSH;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_en", m_mem_en, 1);
      check_eq("stall_addr", m_mem_addr, 2046);
      check_eq("stall_idx", m_word_idx, 1);
      tick();
    end
    op_valid = 1'b0;
    op       = OP_NOP;
    check_eq("stall_sp", m_sp, 2045);
    stall = 1'b0;
    tick();
    check_eq("post_stall_en", m_mem_en, 0);
    check_eq("post_stall_sp", m_sp, 2045);

    // Reset during a two-word op aborts the second beat
    exp_beat(2045, 1'b1, 1'b0);
    do_op(OP_PUSH, 1'b1, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("abort_sp", m_sp, 2047);
    check_eq("abort_en", m_mem_en, 0);
    check_eq("abort_ready", m_ready, 1);
    tick();
    check_eq("abort_no_beat1", m_mem_en, 0);

    // ---------------- four-slot window (limit 2043) ----------------
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_beat(32'(2047 - i), 1'b1, 1'b0);
      do_op(OP_PUSH, 1'b0, 0);
    end
    check_eq("b_full", m_full, 1);
    check_eq("b_full_sp", m_sp, 2043);
    tick();
    do_op(OP_PUSH, 1'b0, 0);
    check_eq("b_ovf", m_ovf, 1);
    check_eq("b_ovf_exc", m_exc, 1);
    check_eq("b_ovf_sp", m_sp, 2043);
    check_eq("b_ovf_no_beat", m_mem_en, 0);
    clear_flags();
    check_eq("b_ovf_cleared", m_ovf, 0);

    exp_beat(2044, 1'b0, 1'b0);
    do_op(OP_POP, 1'b0, 0);
    check_eq("b_pop_sp", m_sp, 2044);
    check_eq("b_not_full", m_full, 0);
    tick();
    do_op(OP_PUSH, 1'b1, 0);
    check_eq("b_push2_ovf", m_ovf, 1);
    check_eq("b_push2_exc", m_exc, 1);
    check_eq("b_push2_sp", m_sp, 2044);
    check_eq("b_push2_no_beat", m_mem_en, 0);
    tick();
    check_eq("b_push2_no_partial", m_mem_en, 0);
    check_eq("b_push2_ready", m_ready, 1);

    tick();
    tick();
    check_eq("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_stack_ctrl
`default_nettype wire

// File: doc/stack_ctrl.md
# stack_ctrl

Parametrised stack-pointer controller for the pipeline's memory stage. It replaces the single-register load-only stack pointer with a full controller: it accepts PUSH / POP / LOAD requests of one or two words, sequences the memory beats, and tracks the stack pointer against a configurable window. It raises sticky overflow and underflow flags and pulses an exception line to the hazard/exception unit.

## Interface
Parameters:
- ADDR_W, 32, width of addresses and SP
- STACK_TOP, 2047, SP value after reset (empty stack; highest slot)
- DEPTH, 2048, number of word slots; LIMIT = STACK_TOP - DEPTH is the full SP value

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- op_valid  in  1  request present
- op  in  2  00 NOP, 01 PUSH, 10 POP, 11 LOAD
- op_words  in  1  0 = one word, 1 = two words (PUSH/POP only)
- load_value  in  ADDR_W  new SP for LOAD
- stall  in  1  freezes every register except under reset
- clr_flags  in  1  clears overflow/underflow
- ready  out  1  controller can accept (combinational: state==IDLE)
- mem_en  out  1  memory beat valid (registered)
- mem_we  out  1  1 = write beat (PUSH), 0 = read beat (POP)
- mem_addr  out  ADDR_W  beat address
- word_idx  out  1  word of a two-word op this beat belongs to
- sp  out  ADDR_W  current stack pointer
- empty, full  out  1  sp==STACK_TOP, sp==LIMIT
- overflow, underflow  out  1  sticky error flags
- exc  out  1  one-cycle pulse on any rejected request

## Operation
- Stack grows down; sp addresses the next free slot. Used = STACK_TOP - sp; free = sp - LIMIT.
- Accept = op_valid & ready & !stall & reset. NOP is accepted with no effect.
- PUSH n: legal iff free >= n. Beats: addr sp (word_idx 0), then sp-1 (word_idx 1); sp -= n.
- POP n: legal iff used >= n. Beats: addr sp+1 (word_idx 1), then sp+2 (word_idx 0), mirroring push order; sp += n.
- LOAD: legal iff LIMIT <= load_value <= STACK_TOP; sp <= load_value; no memory beat. load_value < LIMIT sets overflow; > STACK_TOP sets underflow.
- Illegal request: atomic reject. No beats, sp unchanged, flag set, exc=1 for one cycle. Partial two-word ops are never issued.
- FSM: IDLE -> (legal two-word PUSH/POP) -> SECOND -> IDLE. Single-word ops and LOAD stay in IDLE.
- Flags: set wins over clr_flags in the same cycle. Both flags are cleared only by clr_flags or reset.
- Unsigned arithmetic at ADDR_W. Legality is computed before the update, so no wrap is possible.

## Timing
- Reset (reset==0 at edge): sp=STACK_TOP, state IDLE, mem_en=0, mem_we=0, mem_addr=0, word_idx=0, overflow=0, underflow=0, exc=0. Hence empty=1, full=0, ready=1. Reset mid two-word op aborts it; the second beat is never issued.
- Accept at edge N: beat 0 outputs and the updated sp are valid in cycle N+1. For two-word ops, beat 1 appears in cycle N+2, and ready=0 during N+1.
- Two-word ops can therefore accept again at edge N+2; single-word ops accept back-to-back every cycle.
- mem_en is 0 in any cycle without a beat. exc is asserted in cycle N+1 for a reject at edge N.
- stall=1: all registers hold, so a presented beat stays presented and an exc pulse stretches. op_valid is ignored.

## Structure
- Shared package stack_pkg:
  - op encodings (OP_NOP/PUSH/POP/LOAD)
  - FSM state enum (ST_IDLE, ST_SECOND)
- One sub-module, stack_bounds_check: combinational. Takes sp, op, op_words and load_value; returns legal, set_ovf, set_unf, next_sp.
- stack_ctrl holds the FSM, registers and beat sequencing.

## Test plan
- Reset, then PUSH1 x3 -> beats at 2047, 2046, 2045 with mem_we=1; sp=2044, empty=0.
- After that, POP2 -> ready=0 for one cycle; beats 2045 (word_idx 1) then 2046 (word_idx 0); sp=2046.
- DEPTH=4: push to full, then PUSH1 -> no beat, sp unchanged, overflow=1, exc pulse. With sp=LIMIT+1, PUSH2 -> atomic reject.
- POP1 on empty -> underflow=1, sp=2047. Next, clr_flags together with another illegal POP -> underflow stays 1.
- LOAD 1000 -> sp=1000, no mem_en. LOAD 5000 -> underflow, sp stays 1000.
- PUSH2 with stall asserted during the second beat -> beat 1 held stable while stalled. reset=0 mid-op -> sp=2047, mem_en=0 next cycle.
